// File: rtl/parking_lane_sequencer.sv
// Vehicle-side sequencer for the parking lot controller: queues entry and exit
// arrivals, issues one enter_req/exit_req at a time and reports each outcome.
module parking_lane_sequencer #(
    parameter int unsigned ENTRY_DEPTH  = 4,   // power of two, >= 2
    parameter int unsigned EXIT_CNT_W   = 3,
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter int unsigned GAP          = 2    // >= 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arrive_valid,
    input  logic [7:0]                    arrive_passcode,
    input  logic                          depart_valid,
    output logic [7:0]                    passcode_out,
    output logic                          enter_req,
    output logic                          exit_req,
    input  logic                          entry_gate_open,
    input  logic                          exit_gate_open,
    input  logic                          lot_full,
    input  logic [4:0]                    car_count,
    output logic                          entry_granted,
    output logic                          entry_denied,
    output logic [1:0]                    deny_reason,
    output logic                          exit_done,
    output logic                          exit_denied,
    output logic                          arrive_overflow,
    output logic [$clog2(ENTRY_DEPTH):0]  entry_pending,
    output logic                          busy
);

    localparam int unsigned AW       = $clog2(ENTRY_DEPTH);
    localparam int unsigned PW       = AW + 1;
    localparam int unsigned TW       = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned GW       = $clog2(GAP + 1);
    localparam int unsigned EXIT_MAX = (1 << EXIT_CNT_W) - 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ENTRY,
        WAIT_ENTRY,
        ISSUE_EXIT,
        WAIT_EXIT,
        COOLDOWN
    } state_t;

    state_t                 state;
    logic [7:0]             mem [ENTRY_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [PW-1:0]          fifo_cnt;
    logic [EXIT_CNT_W-1:0]  exit_cnt;
    logic [TW-1:0]          timer;
    logic [GW-1:0]          cool;

    logic                   full_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   exit_inc_c;
    logic                   exit_sat_c;
    logic                   exit_dec_c;
    logic [TW-1:0]          timer_inc_c;
    logic                   timeout_c;

    assign full_c        = (fifo_cnt == PW'(ENTRY_DEPTH));
    assign push_c        = arrive_valid && !full_c;
    assign exit_sat_c    = depart_valid && (exit_cnt == EXIT_CNT_W'(EXIT_MAX));
    assign exit_inc_c    = depart_valid && !exit_sat_c;
    assign timer_inc_c   = timer + TW'(1);
    assign timeout_c     = (timer_inc_c == TW'(RESP_TIMEOUT));
    assign entry_pending = fifo_cnt;

    // Queue pop and exit-count decrement happen on the edge that retires a car
    always_comb begin
        pop_c      = 1'b0;
        exit_dec_c = 1'b0;
        case (state)
            IDLE:       pop_c      = (exit_cnt == '0) && (fifo_cnt != '0) && lot_full;
            WAIT_ENTRY: pop_c      = entry_gate_open || timeout_c;
            ISSUE_EXIT: exit_dec_c = (car_count == '0);
            WAIT_EXIT:  exit_dec_c = exit_gate_open || timeout_c;
            default:    ;
        endcase
    end

    // Passcode storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= arrive_passcode;
        end
    end

    // Entry FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            arrive_overflow <= 1'b0;
        end else begin
            arrive_overflow <= arrive_valid && full_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_cnt <= fifo_cnt + PW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - PW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Saturating count of cars waiting at the exit lane
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exit_cnt <= '0;
        end else begin
            case ({exit_inc_c, exit_dec_c})
                2'b10:   exit_cnt <= exit_cnt + EXIT_CNT_W'(1);
                2'b01:   exit_cnt <= exit_cnt - EXIT_CNT_W'(1);
                default: exit_cnt <= exit_cnt;
            endcase
        end
    end

    // Transaction sequencer; every output here is a registered pulse or level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            cool          <= '0;
            passcode_out  <= '0;
            enter_req     <= 1'b0;
            exit_req      <= 1'b0;
            entry_granted <= 1'b0;
            entry_denied  <= 1'b0;
            deny_reason   <= 2'b00;
            exit_done     <= 1'b0;
            exit_denied   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            enter_req     <= 1'b0;
            exit_req      <= 1'b0;
            entry_granted <= 1'b0;
            entry_denied  <= 1'b0;
            deny_reason   <= 2'b00;
            exit_done     <= 1'b0;
            exit_denied   <= exit_sat_c;
            case (state)
                IDLE: begin
                    cool <= '0;
                    if (exit_cnt != '0) begin
                        // exits first: they free space in the lot
                        busy  <= 1'b1;
                        state <= ISSUE_EXIT;
                    end else if (fifo_cnt != '0) begin
                        busy <= 1'b1;
                        if (lot_full) begin
                            entry_denied <= 1'b1;
                            deny_reason  <= 2'b01;
                            state        <= COOLDOWN;
                        end else begin
                            passcode_out <= mem[rd_ptr];
                            enter_req    <= 1'b1;
                            timer        <= '0;
                            state        <= ISSUE_ENTRY;
                        end
                    end
                end
                ISSUE_ENTRY: begin
                    timer <= timer_inc_c;
                    state <= WAIT_ENTRY;
                end
                WAIT_ENTRY: begin
                    timer <= timer_inc_c;
                    if (entry_gate_open) begin
                        entry_granted <= 1'b1;
                        passcode_out  <= '0;
                        state         <= COOLDOWN;
                    end else if (timeout_c) begin
                        entry_denied <= 1'b1;
                        deny_reason  <= 2'b10;
                        passcode_out <= '0;
                        state        <= COOLDOWN;
                    end
                end
                ISSUE_EXIT: begin
                    if (car_count == '0) begin
                        exit_denied <= 1'b1;
                        state       <= COOLDOWN;
                    end else begin
                        exit_req <= 1'b1;
                        timer    <= '0;
                        state    <= WAIT_EXIT;
                    end
                end
                WAIT_EXIT: begin
                    timer <= timer_inc_c;
                    if (exit_gate_open) begin
                        exit_done <= 1'b1;
                        state     <= COOLDOWN;
                    end else if (timeout_c) begin
                        exit_denied <= 1'b1;
                        state       <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cool == GW'(GAP - 1)) begin
                        cool  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cool <= cool + GW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_lane_sequencer.sv
// Scoreboard bench for parking_lane_sequencer: a burst model predicts the ordered
// car outcomes with their spacing; a monitor pops and compares as pulses appear.
module tb_parking_lane_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RTO   = 8;
    localparam int unsigned GAP   = 2;

    localparam int K_ENTER = 0;
    localparam int K_GRANT = 1;
    localparam int K_DENY  = 2;
    localparam int K_XREQ  = 3;
    localparam int K_XDONE = 4;
    localparam int K_XDENY = 5;

    typedef struct {
        int kind;
        int pc;
        int reason;
        int dly;   // cycles since previous event, -1 = don't care
        int pend;  // expected entry_pending, -1 = don't care
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arrive_valid = 1'b0;
    logic [7:0] arrive_passcode = '0;
    logic       depart_valid = 1'b0;
    logic [7:0] passcode_out;
    logic       enter_req;
    logic       exit_req;
    logic       entry_gate_open = 1'b0;
    logic       exit_gate_open = 1'b0;
    logic       lot_full = 1'b0;
    logic [4:0] car_count = 5'd3;
    logic       entry_granted;
    logic       entry_denied;
    logic [1:0] deny_reason;
    logic       exit_done;
    logic       exit_denied;
    logic       arrive_overflow;
    logic [2:0] entry_pending;
    logic       busy;

    parking_lane_sequencer #(
        .ENTRY_DEPTH(DEPTH), .EXIT_CNT_W(3), .RESP_TIMEOUT(RTO), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .arrive_valid(arrive_valid), .arrive_passcode(arrive_passcode),
        .depart_valid(depart_valid), .passcode_out(passcode_out),
        .enter_req(enter_req), .exit_req(exit_req),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .lot_full(lot_full), .car_count(car_count),
        .entry_granted(entry_granted), .entry_denied(entry_denied),
        .deny_reason(deny_reason), .exit_done(exit_done), .exit_denied(exit_denied),
        .arrive_overflow(arrive_overflow), .entry_pending(entry_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_evt = 0;
    int         ovf_exp = 0;
    int         ent_open = -10;
    int         ext_open = -10;
    int         busy_chk = -10;
    bit         in_entry = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] pcs [5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input int act, input int expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic got_evt(input int kind, input int pc, input int reason);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 1'b0, kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind == e.kind, kind, e.kind);
        if (kind == K_ENTER && e.kind == K_ENTER) chk("enter_passcode", pc == e.pc, pc, e.pc);
        if (kind == K_DENY && e.kind == K_DENY) chk("deny_reason", reason == e.reason, reason, e.reason);
        if (e.dly >= 0) chk("event_delay", (cyc - last_evt) == e.dly, cyc - last_evt, e.dly);
        if (e.pend >= 0) chk("entry_pending", int'(entry_pending) == e.pend, int'(entry_pending), e.pend);
        last_evt = cyc;
        if (exp_q.size() == 0 && e.kind != K_ENTER && e.kind != K_XREQ) busy_chk = cyc + int'(GAP);
    endtask

    // Lot controller stand-in: gate opens two cycles after an accepted request
    always @(posedge clk) begin
        #1;
        entry_gate_open = (cyc == ent_open);
        exit_gate_open  = (cyc == ext_open);
    end

    // Monitor: sample between edges and check against the expected queue
    always @(negedge clk) begin
        if (reset) begin
            if (entry_granted) begin
                in_entry = 1'b0;
                got_evt(K_GRANT, 0, 0);
            end
            if (entry_denied) begin
                in_entry = 1'b0;
                got_evt(K_DENY, 0, int'(deny_reason));
            end
            if (exit_req) begin
                got_evt(K_XREQ, 0, 0);
                ext_open = cyc + 2;
            end
            if (exit_done) got_evt(K_XDONE, 0, 0);
            if (exit_denied) got_evt(K_XDENY, 0, 0);
            if (enter_req) begin
                got_evt(K_ENTER, int'(passcode_out), 0);
                in_entry = 1'b1;
                held = passcode_out;
                if (passcode_out == 8'hFF && car_count < 5'd20) ent_open = cyc + 2;
            end
            if (arrive_overflow) begin
                chk("overflow_expected", ovf_exp > 0, 1, ovf_exp);
                if (ovf_exp > 0) ovf_exp--;
            end
            chk("passcode_bus", in_entry ? (passcode_out == held) : (passcode_out == 8'h00),
                int'(passcode_out), in_entry ? int'(held) : 0);
            chk("req_exclusive", !(enter_req && exit_req), int'({enter_req, exit_req}), 0);
            if (cyc == busy_chk - 1) chk("busy_before_idle", busy == 1'b1, int'(busy), 1);
            if (cyc == busy_chk) chk("busy_after_gap", busy == 1'b0, int'(busy), 0);
        end
    end

    task automatic check_quiet(input string name);
        chk({name, "_pulses"},
            {enter_req, exit_req, entry_granted, entry_denied, deny_reason,
             exit_done, exit_denied, arrive_overflow, busy} == '0,
            int'({enter_req, exit_req, entry_granted, entry_denied, deny_reason,
                  exit_done, exit_denied, arrive_overflow, busy}), 0);
        chk({name, "_passcode"}, passcode_out == 8'h00, int'(passcode_out), 0);
        chk({name, "_pending"}, entry_pending == 3'd0, int'(entry_pending), 0);
    endtask

    function automatic exp_t mk(input int kind, input int pc, input int reason, input int dly, input int pend);
        exp_t e;
        e.kind = kind; e.pc = pc; e.reason = reason; e.dly = dly; e.pend = pend;
        return e;
    endfunction

    // Model a burst of n arrivals (and optional depart) from an idle sequencer, then drive it
    task automatic run_burst(input int n, input bit dep, input bit lf, input int cc);
        int  acc;
        int  d;
        bit  first;
        int  guard;
        acc   = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        first = 1'b1;
        lot_full  = lf;
        car_count = 5'(cc);
        if (dep) begin
            if (cc == 0) begin
                exp_q.push_back(mk(K_XDENY, 0, 0, 3, -1));
            end else begin
                exp_q.push_back(mk(K_XREQ, 0, 0, 3, -1));
                exp_q.push_back(mk(K_XDONE, 0, 0, 3, acc));
            end
            first = 1'b0;
        end
        for (int i = 0; i < acc; i++) begin
            d = first ? 2 : int'(GAP) + 1;
            first = 1'b0;
            if (lf) begin
                exp_q.push_back(mk(K_DENY, 0, 1, d, acc - i - 1));
            end else begin
                exp_q.push_back(mk(K_ENTER, int'(pcs[i]), 0, d, -1));
                if (pcs[i] == 8'hFF && cc < 20)
                    exp_q.push_back(mk(K_GRANT, 0, 0, 3, acc - i - 1));
                else
                    exp_q.push_back(mk(K_DENY, 0, 2, int'(RTO), acc - i - 1));
            end
        end
        ovf_exp = n - acc;
        @(posedge clk); #1;
        last_evt = cyc;
        for (int i = 0; i < 5; i++) begin
            arrive_valid    = (i < n);
            arrive_passcode = pcs[i];
            depart_valid    = dep && (i == 0);
            @(posedge clk); #1;
        end
        arrive_valid = 1'b0;
        depart_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || busy || cyc <= busy_chk) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("burst_timeout", guard < 300, guard, 300);
        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        chk("overflow_count", ovf_exp == 0, ovf_exp, 0);
        chk("pending_after", entry_pending == 3'd0, int'(entry_pending), 0);
        chk("busy_after", busy == 1'b0, int'(busy), 0);
        exp_q.delete();
        ovf_exp  = 0;
        in_entry = 1'b0;
    endtask

    initial begin
        int n;
        bit dep;
        bit lf;
        int ccs [5];
        ccs[0] = 0; ccs[1] = 3; ccs[2] = 19; ccs[3] = 20; ccs[4] = 25;
        for (int i = 0; i < 5; i++) pcs[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);

        pcs[0] = 8'hFF;
        run_burst(1, 1'b0, 1'b0, 3);
        pcs[0] = 8'hFE;
        run_burst(1, 1'b0, 1'b0, 3);
        pcs[0] = 8'h5A; pcs[1] = 8'hFF;
        run_burst(2, 1'b0, 1'b1, 10);
        pcs[0] = 8'hFF; pcs[1] = 8'h11; pcs[2] = 8'hFF; pcs[3] = 8'h22; pcs[4] = 8'hFF;
        run_burst(5, 1'b0, 1'b0, 5);
        pcs[0] = 8'hFF;
        run_burst(1, 1'b1, 1'b0, 3);
        run_burst(0, 1'b1, 1'b0, 0);

        for (int t = 0; t < 30; t++) begin
            lf  = ($urandom % 4) == 0;
            dep = $urandom % 2;
            n   = int'($urandom_range(0, 5));
            if (lf && !dep && n > 2) n = 2;
            if (n == 0 && !dep) n = 1;
            for (int i = 0; i < 5; i++)
                pcs[i] = ($urandom % 2) ? 8'hFF : 8'($urandom % 255);
            run_burst(n, dep, lf, ccs[$urandom % 5]);
        end

        // Reset while waiting on a refused passcode with more cars queued
        lot_full = 1'b0;
        car_count = 5'd3;
        exp_q.push_back(mk(K_ENTER, 8'hFE, 0, 2, -1));
        @(posedge clk); #1;
        last_evt = cyc;
        for (int i = 0; i < 3; i++) begin
            arrive_valid = 1'b1;
            arrive_passcode = 8'hFE;
            @(posedge clk); #1;
        end
        arrive_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_entry_busy", busy == 1'b1, int'(busy), 1);
        reset = 1'b0;
        exp_q.delete();
        in_entry = 1'b0;
        #1;
        check_quiet("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_quiet("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests expected completion", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parking_lane_sequencer.md
Name: parking_lane_sequencer

Overview:
- Vehicle-side initiator for the parking lot controller (the block that accepts passcode_in, enter_req and exit_req, and returns entry_gate_open, exit_gate_open, lot_full and car_count).
- Buffers entry-lane arrivals (with passcodes) and exit-lane arrivals.
- Serialises them into one-at-a-time enter_req/exit_req transactions, waits for the gate response or a timeout, and reports a per-car outcome to the lane signage logic.

Parameters:
- ENTRY_DEPTH, 4: entry FIFO depth in passcodes; power of two, minimum 2.
- EXIT_CNT_W, 3: width of the pending-exit counter; saturates at 2^EXIT_CNT_W-1.
- RESP_TIMEOUT, 8: cycles to wait for a gate-open response after a request pulse.
- GAP, 2: idle cycles forced after every transaction before the next issue.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- arrive_valid  in  1  one-cycle pulse: car at entry lane.
- arrive_passcode  in  8  passcode, sampled with arrive_valid.
- depart_valid  in  1  one-cycle pulse: car at exit lane.
- passcode_out  out  8  drives the controller's passcode_in; held stable through the whole entry transaction.
- enter_req  out  1  one-cycle request pulse to the controller.
- exit_req  out  1  one-cycle request pulse to the controller.
- entry_gate_open  in  1  controller response.
- exit_gate_open  in  1  controller response.
- lot_full  in  1  controller status.
- car_count  in  5  controller status.
- entry_granted  out  1  pulse: head car admitted.
- entry_denied  out  1  pulse: head car refused.
- deny_reason  out  2  valid with entry_denied: 01 lot full (local), 10 timeout/bad passcode.
- exit_done  out  1  pulse: exit gate opened.
- exit_denied  out  1  pulse: exit dropped (lot empty or timeout).
- arrive_overflow  out  1  pulse: arrival dropped because the FIFO was full.
- entry_pending  out  clog2(ENTRY_DEPTH)+1  FIFO occupancy.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; passcode_out=0; FIFO empty; exit counter 0; timers 0; state IDLE.
- FIFO push: arrive_valid with FIFO not full pushes arrive_passcode.
  - If full: drop the arrival, pulse arrive_overflow the next cycle, occupancy unchanged.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Exit counter: depart_valid increments it.
  - At saturation the increment is dropped and exit_denied pulses.
  - Simultaneous increment and decrement leaves the counter unchanged.
- States: IDLE, ISSUE_ENTRY, WAIT_ENTRY, ISSUE_EXIT, WAIT_EXIT, COOLDOWN.
- IDLE arbitration is evaluated every cycle:
  - Exit counter > 0: go to ISSUE_EXIT. Exits have priority because they free space.
  - Otherwise, FIFO non-empty:
    - If lot_full=1: pop the head and pulse entry_denied with deny_reason=01. No enter_req is issued. Go to COOLDOWN.
    - Else: load the head into passcode_out and go to ISSUE_ENTRY.
- ISSUE_ENTRY: enter_req=1 for exactly one cycle; clear the timer; go to WAIT_ENTRY.
- WAIT_ENTRY: the timer increments each cycle.
  - entry_gate_open=1 seen: pop the head, pulse entry_granted, go to COOLDOWN.
  - Timer reaches RESP_TIMEOUT: pop the head, pulse entry_denied with deny_reason=10, go to COOLDOWN.
  - A gate-open in the same cycle as the timeout counts as a grant.
- ISSUE_EXIT:
  - If car_count==0: decrement the exit counter, pulse exit_denied, go to COOLDOWN. No exit_req is issued.
  - Else: exit_req=1 for one cycle, clear the timer, go to WAIT_EXIT.
- WAIT_EXIT: exit_gate_open gives exit_done; timeout gives exit_denied. Either way, decrement the exit counter and go to COOLDOWN.
- COOLDOWN: hold GAP cycles, then go to IDLE.
  - passcode_out returns to 0 on entry to COOLDOWN; passcode must not linger on the bus.
- Pulse outputs are registered and each lasts exactly one cycle.
- At most one of enter_req/exit_req is high in any cycle; no new request is issued while in WAIT_* or COOLDOWN.
- Gate-open inputs seen outside WAIT_* are ignored.
- Reset mid-transaction: immediate return to the reset state; the pending FIFO and exit requests are discarded.
- Latency, idle lot, empty FIFO: arrive_valid at cycle 0 gives enter_req at cycle 2 (FIFO write at 1, IDLE issue decision at 1, ISSUE_ENTRY at 2).

Test Plan:
- Bench responder model: opens the gate 2 cycles after a request if passcode==8'hFF and car_count<20; otherwise never opens.
- Single arrival with 8'hFF, car_count=3: enter_req pulses at cycle 2; passcode_out=8'hFF until the grant; entry_granted one cycle; busy returns to 0 after GAP.
- Arrival with 8'hFE: enter_req issued; no gate; entry_denied with deny_reason=10 exactly RESP_TIMEOUT cycles after enter_req; FIFO drained.
- lot_full=1 with 2 queued arrivals: no enter_req; two entry_denied pulses with deny_reason=01, separated by GAP+1 cycles; entry_pending goes 2 then 1 then 0.
- 5 back-to-back arrivals with ENTRY_DEPTH=4: fifth arrival gives arrive_overflow; exactly 4 enter_req pulses in arrival order.
- Simultaneous depart_valid and arrive_valid: exit_req issued first, then enter_req.
- car_count=0 with depart_valid: exit_denied, no exit_req.
- Reset asserted during WAIT_ENTRY with 3 queued: all outputs 0 at once; after release no request is issued and entry_pending=0.
